// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the 5-stage RV32 core. It owns the PC, issues
// single-beat AXI4 reads to instruction memory and loads the IF/ID pipeline
// register that the ID-stage hazard detector reads.
//
// Only one AXI read is ever outstanding. A fetched word goes straight into
// IF/ID when the pipeline can advance. Otherwise it is parked in a one-entry
// buffer (HOLD) until the pipeline can take it.
//
// Redirects from EX take effect on the PC at once. An AR that is already
// presented keeps its address until accepted. A response that belongs to a
// redirected-away fetch is marked by 'discard' and thrown away on arrival.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   pc_write, if_id_write      hazard-detector enables (both 1 to advance)
//   core_stall                 global freeze; also masks redirect
//   redirect, redirect_pc      taken branch/jal/jalr resolved in EX
//   ar* / arready              AXI4 read-address channel (single beat, INCR)
//   r* / rready                AXI4 read-data channel (rid, rlast ignored)
//   if_id_pc, if_id_inst       IF/ID pipeline register contents
//   if_id_valid                IF/ID holds a real instruction
//   fetch_stall                no instruction available this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ID_W     = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              core_stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_inst,
  output logic              if_id_valid,
  output logic              fetch_stall
);

  // addi x0, x0, 0 -- what IF/ID holds when it carries no real instruction
  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [1:0]        RESP_OK  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [DATA_W-1:0] if_id_inst_q, if_id_inst_d;
  logic              if_id_valid_q, if_id_valid_d;

  logic              redirect_eff;
  logic              rsp_fire;
  logic              avail;
  logic              adv;
  logic [DATA_W-1:0] rsp_word;
  logic [DATA_W-1:0] adv_word;
  logic [ADDR_W-1:0] pc_seq;

  // rid and rlast carry no information for single-beat, single-ID reads
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast};

  // Fixed AR attributes: one 32-bit beat, ID 0, incrementing burst
  assign arid    = '0;
  assign arlen   = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign arvalid = (state_q == S_REQ);
  assign rready  = (state_q == S_WAIT);
  assign araddr  = araddr_q;

  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_valid = if_id_valid_q;

  // Handshake qualifiers. A redirect is ignored while the core is frozen so
  // that EX, which is also frozen, can re-present it later. An error response
  // still completes the fetch but delivers a NOP instead of the bad word.
  always_comb begin
    redirect_eff = redirect & ~core_stall;
    rsp_fire     = (state_q == S_WAIT) & rvalid;
    rsp_word     = (rresp == RESP_OK) ? rdata : NOP;
    avail        = (rsp_fire & ~discard_q) | (state_q == S_HOLD);
    adv          = avail & pc_write & if_id_write & ~core_stall & ~redirect_eff;
    adv_word     = (state_q == S_HOLD) ? buf_q : rsp_word;
    pc_seq       = pc_q + PC_STEP;
    fetch_stall  = ~avail;
  end

  // Next-state logic. The PC and IF/ID are updated the same way whatever the
  // state: a redirect wins over an advance. The per-state part then chooses
  // where the FSM goes and which address the next AR carries. araddr only
  // changes on a transition into REQ, so it stays put for the whole AR.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    araddr_d      = araddr_q;
    buf_d         = buf_q;
    discard_d     = discard_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;

    if (redirect_eff) begin
      pc_d          = redirect_pc;
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP;
    end else if (adv) begin
      pc_d          = pc_seq;
      if_id_pc_d    = pc_q;
      if_id_inst_d  = adv_word;
      if_id_valid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d  = S_REQ;
        araddr_d = redirect_eff ? redirect_pc : pc_q;
      end

      S_REQ: begin
        if (redirect_eff) begin
          discard_d = 1'b1;
        end
        if (arready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
            araddr_d  = redirect_eff ? redirect_pc : pc_q;
          end else if (redirect_eff) begin
            state_d  = S_REQ;
            araddr_d = redirect_pc;
          end else if (adv) begin
            state_d  = S_REQ;
            araddr_d = pc_seq;
          end else begin
            buf_d   = rsp_word;
            state_d = S_HOLD;
          end
        end else if (redirect_eff) begin
          discard_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_eff) begin
          state_d  = S_REQ;
          araddr_d = redirect_pc;
        end else if (adv) begin
          state_d  = S_REQ;
          araddr_d = pc_seq;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset leaves IF/ID holding an invalid NOP
  // and the FSM in IDLE so no AR is raised in the cycle reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      araddr_q      <= RESET_PC;
      buf_q         <= NOP;
      discard_q     <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      araddr_q      <= araddr_d;
      buf_q         <= buf_d;
      discard_q     <= discard_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // AXI requires a presented AR to stay valid and unchanged until accepted
  a_ar_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (arvalid && !arready) |=> (arvalid && $stable(araddr))
  );

  // rready is only raised while a read is outstanding
  a_single_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(arvalid && rready)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed scenarios for the IF stage. Each task drives the AXI side and the
// hazard/EX controls cycle by cycle and compares against hand-derived values.
// Inputs change just after the falling edge. Outputs are observed 1 ns later,
// well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pc_write, if_id_write, core_stall, redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic [ADDR_W-1:0] if_id_pc;
  logic [DATA_W-1:0] if_id_inst;
  logic              if_id_valid, fetch_stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .core_stall(core_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .if_id_valid(if_id_valid), .fetch_stall(fetch_stall)
  );

  task automatic set_defaults();
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    core_stall  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    arready     = 1'b0;
    rid         = '0;
    rdata       = '0;
    rresp       = 2'b00;
    rlast       = 1'b1;
    rvalid      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge in the cycle right after release
  task automatic do_reset();
    rst_n = 1'b0;
    set_defaults();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_defaults();
    @(negedge clk);
    #1;
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_arvalid: got %b expected 0", arvalid); end
    vectors++; if (rready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rready: got %b expected 0", rready); end
    vectors++; if (araddr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_araddr: got %h expected 00000000", araddr); end
    vectors++; if (if_id_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_id_pc: got %h expected 00000000", if_id_pc); end
    vectors++; if (if_id_inst !== NOP) begin miscompares++; $display("[TB] FAIL reset_if_id_inst: got %h expected %h", if_id_inst, NOP); end
    vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_if_id_valid: got %b expected 0", if_id_valid); end
    vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_fetch_stall: got %b expected 1", fetch_stall); end
    vectors++; if (arlen !== 4'd0 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0) begin miscompares++; $display("[TB] FAIL ar_constants: got len=%h size=%b burst=%b id=%h", arlen, arsize, arburst, arid); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
    do_reset();
    arready = 1'b1;
    rvalid  = 1'b1;
    #1;
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_release_arvalid: got %b expected 0", arvalid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_addr = 32'(k * 4);
      exp_word = 32'hA000_0000 + exp_addr;
      rdata = exp_word;
      #1;
      vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_arvalid[%0d]: got %b expected 1", k, arvalid); end
      vectors++; if (araddr !== exp_addr) begin miscompares++; $display("[TB] FAIL stream_araddr[%0d]: got %h expected %h", k, araddr, exp_addr); end
      tick();
      #1;
      vectors++; if (rready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_rready[%0d]: got %b expected 1", k, rready); end
      if (k == 0) begin
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_valid_early: got %b expected 0", if_id_valid); end
      end
      tick();
      vectors++; if (if_id_pc !== exp_addr) begin miscompares++; $display("[TB] FAIL stream_if_id_pc[%0d]: got %h expected %h", k, if_id_pc, exp_addr); end
      vectors++; if (if_id_inst !== exp_word) begin miscompares++; $display("[TB] FAIL stream_if_id_inst[%0d]: got %h expected %h", k, if_id_inst, exp_word); end
      vectors++; if (if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_if_id_valid[%0d]: got %b expected 1", k, if_id_valid); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    arready = 1'b1;
    tick();
    tick();
    rvalid      = 1'b1;
    rdata       = 32'h0050_0093;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    #1;
    vectors++; if (rready !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_rready: got %b expected 1", rready); end
    tick();
    rvalid = 1'b0;
    rdata  = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_no_ar[%0d]: got %b expected 0", k, arvalid); end
      vectors++; if (fetch_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_avail[%0d]: got %b expected 0", k, fetch_stall); end
      vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_if_id_frozen[%0d]: got %b expected 0", k, if_id_valid); end
      tick();
    end
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    tick();
    #1;
    vectors++; if (if_id_inst !== 32'h0050_0093) begin miscompares++; $display("[TB] FAIL hold_if_id_inst: got %h expected 00500093", if_id_inst); end
    vectors++; if (if_id_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL hold_if_id_pc: got %h expected 00000000", if_id_pc); end
    vectors++; if (if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_if_id_valid: got %b expected 1", if_id_valid); end
    vectors++; if (araddr !== 32'h4 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_next_ar: got %h/%b expected 00000004/1", araddr, arvalid); end
  endtask

  task automatic test_redirect_req();
    do_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    vectors++; if (araddr !== 32'h0 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdreq_ar_c0: got %h/%b expected 00000000/1", araddr, arvalid); end
    tick();
    redirect = 1'b0;
    #1;
    vectors++; if (araddr !== 32'h0 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdreq_ar_c1: got %h/%b expected 00000000/1", araddr, arvalid); end
    tick();
    arready = 1'b1;
    #1;
    vectors++; if (araddr !== 32'h0) begin miscompares++; $display("[TB] FAIL rdreq_ar_accept: got %h expected 00000000", araddr); end
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    #1;
    vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rdreq_discard_stall: got %b expected 1", fetch_stall); end
    tick();
    rvalid = 1'b0;
    #1;
    vectors++; if (araddr !== 32'h100 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdreq_new_ar: got %h/%b expected 00000100/1", araddr, arvalid); end
    vectors++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin miscompares++; $display("[TB] FAIL rdreq_if_id_dropped: got %b/%h expected 0/%h", if_id_valid, if_id_inst, NOP); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0010_0513;
    tick();
    rvalid = 1'b0;
    #1;
    vectors++; if (if_id_pc !== 32'h100 || if_id_inst !== 32'h0010_0513 || if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdreq_target_fetch: got %h/%h/%b expected 00000100/00100513/1", if_id_pc, if_id_inst, if_id_valid); end
    vectors++; if (araddr !== 32'h104) begin miscompares++; $display("[TB] FAIL rdreq_after_target: got %h expected 00000104", araddr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    arready = 1'b1;
    rvalid  = 1'b1;
    rdata   = 32'h0AAA_0AAA;
    tick();
    tick();
    tick();
    vectors++; if (if_id_inst !== 32'h0AAA_0AAA || if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdwait_first: got %h/%b expected 0aaa0aaa/1", if_id_inst, if_id_valid); end
    rvalid = 1'b0;
    tick();
    rvalid      = 1'b1;
    rdata       = 32'h1111_1111;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    rvalid   = 1'b0;
    redirect = 1'b0;
    #1;
    vectors++; if (if_id_inst !== NOP) begin miscompares++; $display("[TB] FAIL rdwait_if_id_inst: got %h expected %h", if_id_inst, NOP); end
    vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rdwait_if_id_valid: got %b expected 0", if_id_valid); end
    vectors++; if (araddr !== 32'h200 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdwait_next_ar: got %h/%b expected 00000200/1", araddr, arvalid); end
  endtask

  task automatic test_core_stall();
    do_reset();
    arready = 1'b1;
    tick();
    tick();
    arready    = 1'b0;
    core_stall = 1'b1;
    #1;
    vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL cstall_no_word: got %b expected 1", fetch_stall); end
    tick();
    rvalid = 1'b1;
    rdata  = 32'h00A0_0113;
    tick();
    rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++; if (fetch_stall !== 1'b0 || arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL cstall_hold[%0d]: got stall=%b arvalid=%b expected 0/0", k, fetch_stall, arvalid); end
      vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL cstall_if_id_frozen[%0d]: got %b expected 0", k, if_id_valid); end
      tick();
    end
    core_stall = 1'b0;
    tick();
    #1;
    vectors++; if (if_id_inst !== 32'h00A0_0113 || if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL cstall_release: got %h/%h/%b expected 00a00113/00000000/1", if_id_inst, if_id_pc, if_id_valid); end
    vectors++; if (araddr !== 32'h4 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL cstall_next_ar: got %h/%b expected 00000004/1", araddr, arvalid); end
  endtask

  task automatic test_rresp_error();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    redirect = 1'b0;
    arready  = 1'b1;
    #1;
    vectors++; if (araddr !== 32'h20 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rresp_ar: got %h/%b expected 00000020/1", araddr, arvalid); end
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rresp   = 2'b10;
    rdata   = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    rresp  = 2'b00;
    #1;
    vectors++; if (if_id_inst !== NOP) begin miscompares++; $display("[TB] FAIL rresp_inst: got %h expected %h", if_id_inst, NOP); end
    vectors++; if (if_id_pc !== 32'h20 || if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rresp_pc: got %h/%b expected 00000020/1", if_id_pc, if_id_valid); end
    vectors++; if (araddr !== 32'h24) begin miscompares++; $display("[TB] FAIL rresp_next_ar: got %h expected 00000024", araddr); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    arready = 1'b1;
    rvalid  = 1'b1;
    rdata   = 32'h0BBB_0BBB;
    tick();
    tick();
    tick();
    rvalid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (arvalid !== 1'b0 || rready !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_handshake: got ar=%b r=%b expected 0/0", arvalid, rready); end
    vectors++; if (araddr !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_araddr: got %h expected 00000000", araddr); end
    vectors++; if (if_id_inst !== NOP || if_id_valid !== 1'b0 || if_id_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_if_id: got %h/%h/%b expected 00000000/%h/0", if_id_pc, if_id_inst, if_id_valid, NOP); end
    vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_fetch_stall: got %b expected 1", fetch_stall); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_release_arvalid: got %b expected 0", arvalid); end
    tick();
    #1;
    vectors++; if (araddr !== 32'h0 || arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_first_ar: got %h/%b expected 00000000/1", araddr, arvalid); end
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_streaming();
    test_hold();
    test_redirect_req();
    test_redirect_wait();
    test_core_stall();
    test_rresp_error();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
